// File: rtl/sipo_deserializer_pkg.sv
// Shared constants and types for the serial-in/parallel-out deserializer.
// Holds the default word width, counter-width helper and bit-order encoding.
package sipo_deserializer_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } bit_order_e;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Shift register and bit-position counter; flags the edge that completes a word
// and presents the assembled word (including the bit captured on that edge).
module sipo_shift_core
    import sipo_deserializer_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_in,
    input  logic          serial_en,
    input  logic          sync_clr,
    output logic          word_done,
    output logic [N-1:0]  word,
    output logic [CW-1:0] bit_cnt
);

    localparam bit_order_e ORDER = MSB_FIRST ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;

    logic [N-1:0]  sreg;
    logic [N-1:0]  shift_next;
    logic [CW-1:0] cnt;
    logic          capture;

    generate
        if (ORDER == ORDER_MSB_FIRST) begin : g_msb
            assign shift_next = {sreg[N-2:0], serial_in};
        end else begin : g_lsb
            assign shift_next = {serial_in, sreg[N-1:1]};
        end
    endgenerate

    assign capture   = serial_en & ~sync_clr;
    assign word_done = capture & (cnt == CW'(N - 1));
    // Word is taken from the next-state value so it is usable on the completing edge.
    assign word      = shift_next;
    assign bit_cnt   = cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (sync_clr) begin
            cnt <= '0;
        end else if (serial_en) begin
            sreg <= shift_next;
            cnt  <= word_done ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-to-parallel deserializer: one-word holding buffer with valid/ready
// output handshake and a sticky overrun flag for words dropped while full.
module sipo_deserializer
    import sipo_deserializer_pkg::*;
#(
    parameter int N         = DEFAULT_N,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = cnt_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          serial_in,
    input  logic          serial_en,
    input  logic          sync_clr,
    input  logic          ovr_clr,
    input  logic          data_ready,
    output logic [N-1:0]  data_out,
    output logic          data_valid,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun
);

    logic         word_done;
    logic [N-1:0] word;
    logic         xfer;
    logic         load;
    logic         drop;

    sipo_shift_core #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .serial_in (serial_in),
        .serial_en (serial_en),
        .sync_clr  (sync_clr),
        .word_done (word_done),
        .word      (word),
        .bit_cnt   (bit_cnt)
    );

    assign xfer = data_valid & data_ready;
    assign load = word_done & (~data_valid | data_ready);
    assign drop = word_done & data_valid & ~data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
        end else if (load) begin
            data_out   <= word;
            data_valid <= 1'b1;
        end else if (xfer) begin
            data_valid <= 1'b0;
        end
    end

    // A drop on the same edge as a clear wins so no overrun event is lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed test of the deserializer: an MSB-first and an LSB-first instance
// share the same stimulus and are checked against hand-computed words.
module tb_sipo_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b0;
    logic       serial_en = 1'b0;
    logic       sync_clr = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       data_ready = 1'b0;

    logic [3:0] m_data;
    logic       m_valid;
    logic [1:0] m_cnt;
    logic       m_ovr;
    logic [3:0] l_data;
    logic       l_valid;
    logic [1:0] l_cnt;
    logic       l_ovr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo_deserializer #(.N(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .serial_en  (serial_en),
        .sync_clr   (sync_clr),
        .ovr_clr    (ovr_clr),
        .data_ready (data_ready),
        .data_out   (m_data),
        .data_valid (m_valid),
        .bit_cnt    (m_cnt),
        .overrun    (m_ovr)
    );

    sipo_deserializer #(.N(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .serial_in  (serial_in),
        .serial_en  (serial_en),
        .sync_clr   (sync_clr),
        .ovr_clr    (ovr_clr),
        .data_ready (data_ready),
        .data_out   (l_data),
        .data_valid (l_valid),
        .bit_cnt    (l_cnt),
        .overrun    (l_ovr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        serial_en = 1'b1;
        serial_in = b;
        step();
        serial_en = 1'b0;
    endtask

    task automatic idle_cycle();
        serial_en = 1'b0;
        step();
    endtask

    task automatic drain();
        data_ready = 1'b1;
        idle_cycle();
        data_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({m_data, m_valid, m_cnt, m_ovr} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_msb got %h exp 00", {m_data, m_valid, m_cnt, m_ovr});
        end
        n_cmp++;
        if ({l_data, l_valid, l_cnt, l_ovr} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_lsb got %h exp 00", {l_data, l_valid, l_cnt, l_ovr});
        end
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_first_word();
        send_bit(1'b0);
        send_bit(1'b1);
        n_cmp++;
        if (m_cnt !== 2'd2) begin
            n_err++;
            $display("FAIL t1_bitcnt_mid got %0d exp 2", m_cnt);
        end
        send_bit(1'b1);
        send_bit(1'b0);
        n_cmp++;
        if ({m_data, m_valid, m_cnt, m_ovr} !== {4'b0110, 1'b1, 2'd0, 1'b0}) begin
            n_err++;
            $display("FAIL t1_word got %b exp 0110_1_00_0", {m_data, m_valid, m_cnt, m_ovr});
        end
        n_cmp++;
        if (l_data !== 4'b0110) begin
            n_err++;
            $display("FAIL t1_lsb_word got %b exp 0110", l_data);
        end
    endtask

    task automatic test_overrun();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        n_cmp++;
        if ({m_data, m_valid, m_ovr} !== {4'b0110, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL t2_overrun got %b exp 0110_1_1", {m_data, m_valid, m_ovr});
        end
        ovr_clr = 1'b1;
        idle_cycle();
        ovr_clr = 1'b0;
        n_cmp++;
        if ({m_ovr, l_ovr, m_valid} !== 3'b001) begin
            n_err++;
            $display("FAIL t2_ovr_clr got %b exp 001", {m_ovr, l_ovr, m_valid});
        end
    endtask

    task automatic test_back_to_back();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        data_ready = 1'b1;
        send_bit(1'b1);
        data_ready = 1'b0;
        n_cmp++;
        if ({m_data, m_valid, m_ovr} !== {4'b1001, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL t3_b2b got %b exp 1001_1_0", {m_data, m_valid, m_ovr});
        end
        drain();
        n_cmp++;
        if (m_valid !== 1'b0) begin
            n_err++;
            $display("FAIL t3_drain_valid got %b exp 0", m_valid);
        end
    endtask

    task automatic test_sync_clr();
        send_bit(1'b1);
        send_bit(1'b1);
        n_cmp++;
        if (m_cnt !== 2'd2) begin
            n_err++;
            $display("FAIL t4_cnt_pre got %0d exp 2", m_cnt);
        end
        sync_clr  = 1'b1;
        serial_en = 1'b1;
        serial_in = 1'b1;
        step();
        sync_clr  = 1'b0;
        serial_en = 1'b0;
        n_cmp++;
        if ({m_cnt, m_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL t4_cnt_post got %b exp 000", {m_cnt, m_valid});
        end
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        n_cmp++;
        if ({m_data, m_valid} !== {4'b0011, 1'b1}) begin
            n_err++;
            $display("FAIL t4_word got %b exp 0011_1", {m_data, m_valid});
        end
        n_cmp++;
        if (l_data !== 4'b1100) begin
            n_err++;
            $display("FAIL t4_lsb_word got %b exp 1100", l_data);
        end
        drain();
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        bits = 4'b1010;
        for (int i = 3; i >= 0; i--) begin
            send_bit(bits[i]);
            if (i != 0) begin
                idle_cycle();
                idle_cycle();
                n_cmp++;
                if (m_cnt !== 2'(4 - i)) begin
                    n_err++;
                    $display("FAIL t5_gap_hold got %0d exp %0d", m_cnt, 4 - i);
                end
            end
        end
        n_cmp++;
        if ({m_data, m_valid} !== {4'b1010, 1'b1}) begin
            n_err++;
            $display("FAIL t5_word got %b exp 1010_1", {m_data, m_valid});
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        n_cmp++;
        if ({m_cnt, m_valid, m_ovr} !== 4'b1111) begin
            n_err++;
            $display("FAIL t6_pre got %b exp 1111", {m_cnt, m_valid, m_ovr});
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({m_data, m_valid, m_cnt, m_ovr} !== 8'h00) begin
            n_err++;
            $display("FAIL t6_async_msb got %h exp 00", {m_data, m_valid, m_cnt, m_ovr});
        end
        n_cmp++;
        if ({l_data, l_valid, l_cnt, l_ovr} !== 8'h00) begin
            n_err++;
            $display("FAIL t6_async_lsb got %h exp 00", {l_data, l_valid, l_cnt, l_ovr});
        end
        #3 rst = 1'b1;
        idle_cycle();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        n_cmp++;
        if ({m_data, m_valid, l_data, l_valid} !== {4'b0110, 1'b1, 4'b0110, 1'b1}) begin
            n_err++;
            $display("FAIL t6_fresh got %b exp 0110_1_0110_1", {m_data, m_valid, l_data, l_valid});
        end
        drain();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        n_cmp++;
        if ({m_data, l_data, m_ovr, l_ovr} !== {4'b1000, 4'b0001, 2'b00}) begin
            n_err++;
            $display("FAIL t6_order got %b exp 1000_0001_00", {m_data, l_data, m_ovr, l_ovr});
        end
    endtask

    initial begin
        test_reset();
        test_first_word();
        test_overrun();
        test_back_to_back();
        test_sync_clr();
        test_gaps();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
